// File: rtl/mario_pkg.sv
// Shared types and playfield constants for the player, wall detector and renderers.
package mario_pkg;

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    FALL   = 2'd2
  } motion_state_t;

  localparam int Y_GROUND = 368;
  localparam int BG_MAX   = 400;

endpackage

// File: rtl/frame_tick_sync.sv
// Brings the vsync-rate frame_clk into the Clk domain and emits a 1-cycle tick
// on each rising edge of the synchronized signal.
module frame_tick_sync (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  output logic tick
);

  // [0],[1] form the synchronizer; [2] holds the previous synced value.
  logic [2:0] sync_q;

  always_ff @(posedge Clk) begin
    if (Reset) sync_q <= 3'b000;
    else       sync_q <= {sync_q[1:0], frame_clk};
  end

  assign tick = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/player_motion.sv
// Per-frame player kinematics: horizontal world column stepping plus a
// GROUND/RISE/FALL vertical FSM with jump, gravity and terminal fall speed.
module player_motion #(
  parameter int Y_GROUND = mario_pkg::Y_GROUND,
  parameter int Y_MIN    = 0,
  parameter int BG_MAX   = mario_pkg::BG_MAX,
  parameter int JUMP_V   = 12,
  parameter int GRAVITY  = 1,
  parameter int MAX_FALL = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_jump,
  input  logic       can_up,
  input  logic       can_down,
  input  logic       can_left,
  input  logic       can_right,
  output logic [9:0] y_pos,
  output logic [8:0] bg_step,
  output logic       airborne,
  output logic       facing_left
);
  import mario_pkg::motion_state_t;
  import mario_pkg::GROUND;
  import mario_pkg::RISE;
  import mario_pkg::FALL;

  localparam logic [9:0]  Y_GND   = 10'(Y_GROUND);
  localparam logic [9:0]  Y_TOP   = 10'(Y_MIN);
  localparam logic [10:0] Y_GND_W = 11'(Y_GROUND);
  localparam logic [10:0] Y_TOP_W = 11'(Y_MIN);
  localparam logic [8:0]  BG_TOP  = 9'(BG_MAX);
  localparam logic [4:0]  V_JUMP  = 5'(JUMP_V);
  localparam logic [4:0]  V_GRAV  = 5'(GRAVITY);
  localparam logic [4:0]  V_MAX   = 5'(MAX_FALL);

  logic          tick;
  motion_state_t state_q, state_n;
  logic [9:0]    y_q, y_n;
  logic [8:0]    bg_q, bg_n;
  logic [4:0]    v_q, v_n;
  logic          face_q, face_n;
  logic          jump_req_q, jump_req_n;
  logic          jump_prev_q;
  logic          jump_edge, supported;
  logic [10:0]   y_wide, v_wide, y_rise, y_fall;
  logic [5:0]    v_inc;

  frame_tick_sync u_tick (
    .Clk      (Clk),
    .Reset    (Reset),
    .frame_clk(frame_clk),
    .tick     (tick)
  );

  assign jump_edge = key_jump & ~jump_prev_q;
  assign supported = ~can_down | (y_q >= Y_GND);
  assign y_wide    = {1'b0, y_q};
  assign v_wide    = {6'd0, v_q};
  assign y_rise    = y_wide - v_wide;
  assign y_fall    = y_wide + v_wide;
  assign v_inc     = {1'b0, v_q} + {1'b0, V_GRAV};

  always_comb begin
    state_n    = state_q;
    y_n        = y_q;
    bg_n       = bg_q;
    v_n        = v_q;
    face_n     = face_q;
    jump_req_n = jump_req_q | jump_edge;

    if (tick) begin
      // The request only lives for one frame; an edge landing on the tick
      // cycle itself is carried into the next frame.
      jump_req_n = jump_edge;

      if (key_right && !key_left) begin
        face_n = 1'b0;
        if (can_right && bg_q < BG_TOP) bg_n = bg_q + 9'd1;
      end else if (key_left && !key_right) begin
        face_n = 1'b1;
        if (can_left && bg_q != 9'd0) bg_n = bg_q - 9'd1;
      end

      case (state_q)
        GROUND: begin
          if (jump_req_q && can_up) begin
            state_n = RISE;
            v_n     = V_JUMP;
          end else if (!supported) begin
            state_n = FALL;
            v_n     = 5'd0;
          end
        end
        RISE: begin
          if (!can_up || v_q == 5'd0) begin
            state_n = FALL;
            v_n     = 5'd0;
          end else begin
            y_n = (y_wide < Y_TOP_W + v_wide) ? Y_TOP : y_rise[9:0];
            v_n = (v_q >= V_GRAV) ? v_q - V_GRAV : 5'd0;
          end
        end
        FALL: begin
          if (supported) begin
            state_n = GROUND;
            v_n     = 5'd0;
            if (y_q > Y_GND) y_n = Y_GND;
          end else begin
            y_n = (y_fall > Y_GND_W) ? Y_GND : y_fall[9:0];
            v_n = (v_inc > {1'b0, V_MAX}) ? V_MAX : v_inc[4:0];
          end
        end
        default: begin
          state_n = GROUND;
          v_n     = 5'd0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= GROUND;
      y_q         <= Y_GND;
      bg_q        <= 9'd0;
      v_q         <= 5'd0;
      face_q      <= 1'b0;
      jump_req_q  <= 1'b0;
      // Track the key through reset so a held key does not look like a new press.
      jump_prev_q <= key_jump;
    end else begin
      state_q     <= state_n;
      y_q         <= y_n;
      bg_q        <= bg_n;
      v_q         <= v_n;
      face_q      <= face_n;
      jump_req_q  <= jump_req_n;
      jump_prev_q <= key_jump;
    end
  end

  assign y_pos       = y_q;
  assign bg_step     = bg_q;
  assign airborne    = (state_q != GROUND);
  assign facing_left = face_q;

endmodule

// File: tb/tb_player_motion.sv
// Self-checking bench for player_motion: directed frame table, hand-built
// corner sequences, then randomized frames against a behavioural model.
module tb_player_motion;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic       key_left = 1'b0, key_right = 1'b0, key_jump = 1'b0;
  logic       can_up = 1'b1, can_down = 1'b0, can_left = 1'b1, can_right = 1'b1;
  logic [9:0] y_pos;
  logic [8:0] bg_step;
  logic       airborne, facing_left;

  player_motion dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
    .key_left(key_left), .key_right(key_right), .key_jump(key_jump),
    .can_up(can_up), .can_down(can_down), .can_left(can_left), .can_right(can_right),
    .y_pos(y_pos), .bg_step(bg_step), .airborne(airborne), .facing_left(facing_left)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit l, r, jmp, cu, cl, cr, cd, floor;
    int ey, ebg;
    bit eair, eface;
  } vec_t;
  vec_t tv[$];

  int jy [30] = '{368,356,345,335,326,318,311,305,300,296,293,291,290,290,290,
                  291,293,296,300,305,311,318,326,334,342,350,358,366,368,368};

  // behavioural model state
  int m_y, m_bg, m_mode, m_v;
  bit m_face, m_jreq;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input int ey, input int ebg, input int eair, input int eface);
    chk({nm, " y_pos"}, int'(y_pos), ey);
    chk({nm, " bg_step"}, int'(bg_step), ebg);
    chk({nm, " airborne"}, int'(airborne), eair);
    chk({nm, " facing_left"}, int'(facing_left), eface);
  endtask

  task automatic frame();
    @(negedge Clk) frame_clk = 1'b1;
    repeat (4) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
  endtask

  task automatic pulse_jump();
    @(negedge Clk) key_jump = 1'b1;
    @(negedge Clk) key_jump = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge Clk) Reset = 1'b1;
    @(negedge Clk) Reset = 1'b0;
  endtask

  task automatic set_in(input bit l, r, cu, cd, cl, cr);
    key_left = l; key_right = r;
    can_up = cu; can_down = cd; can_left = cl; can_right = cr;
  endtask

  function automatic void add(bit l, r, jmp, cu, cl, cr, cd, floor, int ey, ebg, bit eair, eface);
    vec_t v;
    v = '{l, r, jmp, cu, cl, cr, cd, floor, ey, ebg, eair, eface};
    tv.push_back(v);
  endfunction

  function automatic void ref_reset();
    m_y = 368; m_bg = 0; m_mode = 0; m_v = 0; m_face = 0; m_jreq = 0;
  endfunction

  // One frame of motion straight from the written rules, using plain ints.
  function automatic void ref_tick(bit l, r, cu, cd, cl, cr);
    bit sup;
    sup = !cd || m_y >= 368;
    if (r && !l) begin
      m_face = 0;
      if (cr && m_bg < 400) m_bg = m_bg + 1;
    end else if (l && !r) begin
      m_face = 1;
      if (cl && m_bg > 0) m_bg = m_bg - 1;
    end
    case (m_mode)
      0: if (m_jreq && cu) begin m_mode = 1; m_v = 12; end
         else if (!sup) begin m_mode = 2; m_v = 0; end
      1: if (!cu || m_v == 0) begin m_mode = 2; m_v = 0; end
         else begin
           m_y = (m_y - m_v < 0) ? 0 : m_y - m_v;
           m_v = (m_v - 1 < 0) ? 0 : m_v - 1;
         end
      default: if (sup) begin
           m_mode = 0; m_v = 0;
           if (m_y > 368) m_y = 368;
         end else begin
           m_y = (m_y + m_v > 368) ? 368 : m_y + m_v;
           m_v = (m_v + 1 > 8) ? 8 : m_v + 1;
         end
    endcase
    m_jreq = 0;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev_y;
    bit l, r, cu, cd, cl, cr;

    // ---- directed frame table ----
    for (int i = 0; i < 10; i++) add(0,1,0, 1,1,1,1,0, 368, i+1, 0, 0);
    for (int i = 0; i < 30; i++) add(0,0,(i==0), 1,1,1,0,1, jy[i], 10, (i < 29), 0);
    for (int i = 0; i < 13; i++) add(1,0,0, 1,1,1,0,1, 368, (i < 10) ? 9-i : 0, 0, 1);
    for (int i = 0; i < 70; i++) add(0,1,0, 1,1,1,0,1, 368, i+1, 0, 0);
    add(0,1,0, 1,1,0,0,1, 368, 70, 0, 0);
    add(0,1,0, 1,1,0,0,1, 368, 70, 0, 0);
    add(0,0,0, 1,1,0,0,1, 368, 70, 0, 0);
    add(0,1,0, 1,1,1,0,1, 368, 71, 0, 0);
    for (int i = 0; i < 332; i++) add(0,1,0, 1,1,1,0,1, 368, (i < 329) ? 72+i : 400, 0, 0);

    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    chk_all("reset", 368, 0, 0, 0);

    prev_y = 368;
    foreach (tv[i]) begin
      if (tv[i].jmp) pulse_jump();
      set_in(tv[i].l, tv[i].r, tv[i].cu, tv[i].floor ? (prev_y < 368) : tv[i].cd, tv[i].cl, tv[i].cr);
      frame();
      chk_all($sformatf("vec%0d", i), tv[i].ey, tv[i].ebg, tv[i].eair, tv[i].eface);
      prev_y = tv[i].ey;
    end

    // ---- jump edge on the tick cycle waits for the next frame ----
    set_in(0,0, 1,0,1,1);
    @(negedge Clk) frame_clk = 1'b1;
    @(negedge Clk);
    @(negedge Clk) key_jump = 1'b1;
    @(negedge Clk) key_jump = 1'b0;
    repeat (2) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
    chk_all("edge_on_tick", 368, 400, 0, 0);
    frame();
    chk_all("edge_next_frame", 368, 400, 1, 0);
    set_in(0,0, 1,1,1,1);
    frame();
    chk_all("rise1", 356, 400, 1, 0);

    // ---- ceiling hit, then a platform catches the fall ----
    set_in(0,0, 0,1,1,1);
    frame();
    chk_all("ceiling", 356, 400, 1, 0);
    set_in(0,0, 1,0,1,1);
    frame();
    chk_all("platform_land", 356, 400, 0, 0);
    frame();
    chk_all("platform_hold", 356, 400, 0, 0);
    set_in(0,0, 1,1,1,1);
    frame();
    chk_all("walk_off", 356, 400, 1, 0);
    frame();
    chk_all("fall_v0", 356, 400, 1, 0);
    frame();
    chk_all("fall_v1", 357, 400, 1, 0);

    // ---- land, jump to apex, reset there ----
    for (int k = 0; k < 40 && airborne; k++) begin
      can_down = (y_pos < 10'd368);
      frame();
    end
    chk_all("landed", 368, 400, 0, 0);
    pulse_jump();
    prev_y = 368;
    for (int k = 0; k < 13; k++) begin
      set_in(0,0, 1, prev_y < 368, 1,1);
      frame();
      prev_y = jy[k];
    end
    chk_all("apex", 290, 400, 1, 0);
    pulse_jump();
    do_reset();
    chk_all("reset_apex", 368, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      set_in(0,0, 1,0,1,1);
      frame();
      chk_all($sformatf("dropped_jump%0d", k), 368, 0, 0, 0);
    end

    // ---- randomized frames vs model ----
    do_reset();
    ref_reset();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        do_reset();
        ref_reset();
      end
      if ($urandom_range(0, 3) == 0) begin
        pulse_jump();
        m_jreq = 1;
      end
      l  = ($urandom_range(0, 2) == 0);
      r  = ($urandom_range(0, 1) == 0);
      cu = ($urandom_range(0, 7) != 0);
      cl = ($urandom_range(0, 5) != 0);
      cr = ($urandom_range(0, 5) != 0);
      cd = ($urandom_range(0, 3) != 0) ? (m_y < 368) : 1'($urandom_range(0, 1));
      set_in(l, r, cu, cd, cl, cr);
      frame();
      ref_tick(l, r, cu, cd, cl, cr);
      chk_all($sformatf("rnd%0d", i), m_y, m_bg, (m_mode != 0), m_face);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/player_motion.md
# player_motion

Per-frame player kinematics for the side-scroller. Consumes the wall detector's `can_up/can_down/can_left/can_right` and the decoded key inputs, and owns the player's vertical position `y_pos` and world column `bg_step`. Both registers feed back into the wall detector and into the sprite and background renderers. Horizontal motion is one world column per frame, so the detector's exact-equality tube-edge checks stay valid.

## Interface
Parameters:
- `Y_GROUND`, 368: floor row; largest legal `y_pos`.
- `Y_MIN`, 0: ceiling row; smallest legal `y_pos`.
- `BG_MAX`, 400: largest `bg_step`.
- `JUMP_V`, 12: initial upward speed, in px/frame.
- `GRAVITY`, 1: speed change per frame.
- `MAX_FALL`, 8: terminal fall speed, in px/frame.

Ports (one clock; reset is synchronous and active-high):
- `Clk` in 1: system clock.
- `Reset` in 1: synchronous, active-high.
- `frame_clk` in 1: VGA vsync-rate strobe, asynchronous to `Clk`.
- `key_left`, `key_right`, `key_jump` in 1 each: decoded key levels, synchronous to `Clk`.
- `can_up`, `can_down`, `can_left`, `can_right` in 1 each: from the wall detector.
- `y_pos` out 10: player top row, in screen pixels.
- `bg_step` out 9: player world column.
- `airborne` out 1: high in RISE or FALL.
- `facing_left` out 1: last horizontal direction, used for sprite mirroring.

## Operation
- Frame tick: `frame_clk` passes through a 2-flop synchronizer; a rising edge of the synced signal gives a 1-`Clk` `tick`. All position/state updates happen only on `tick`.
- Jump request: a rising edge of `key_jump` sets `jump_req`. `jump_req` clears on the next `tick`, whether or not it was consumed. Only one frame of buffering.
- `supported` = `!can_down || y_pos >= Y_GROUND`.
- Horizontal, on `tick`:
  - right only and `can_right` and `bg_step < BG_MAX`: `bg_step+1`, `facing_left=0`.
  - left only and `can_left` and `bg_step > 0`: `bg_step-1`, `facing_left=1`.
  - both or neither pressed: no change. Saturating at both ends; never wraps.
- Vertical FSM (`GROUND`, `RISE`, `FALL`); speed `v` is a 5-bit unsigned magnitude.
  - GROUND:
    - `jump_req && can_up`: go to RISE, `v=JUMP_V`.
    - else `!supported`: go to FALL, `v=0`.
    - else stay; `y_pos` unchanged.
  - RISE:
    - `!can_up || v==0`: go to FALL, `v=0`, `y_pos` unchanged.
    - else `y_pos = max(y_pos-v, Y_MIN)`, `v -= GRAVITY` (floor 0).
  - FALL:
    - `supported`: go to GROUND, `v=0`; if `y_pos > Y_GROUND`, snap to `Y_GROUND`.
    - else `y_pos = min(y_pos+v, Y_GROUND)`, `v = min(v+GRAVITY, MAX_FALL)`.
- Horizontal and vertical updates use the same `tick` and the same sampled `can_*`. Simultaneous moves are allowed.
- All arithmetic is done in 11 bits before clamping, so `y_pos` never underflows or overflows.

## Timing
- Reset values: `y_pos=Y_GROUND`, `bg_step=0`, state GROUND, `v=0`, `jump_req=0`, `airborne=0`, `facing_left=0`, synchronizer flops 0.
- Latency: rise of `frame_clk` to `tick` is 2–3 `Clk`; outputs update on the `Clk` edge ending the `tick` cycle.
- `can_*` are combinational functions of the registered outputs and are sampled only in the `tick` cycle.
- `Reset` has priority over `tick`. Reset during a jump returns to GROUND/floor on the next edge; a pending `jump_req` is dropped.
- A `key_jump` edge in the same cycle as `tick` is latched for the following frame, not the current one.

## Structure
- `mario_pkg` holds:
  - `motion_state_t` enum {GROUND, RISE, FALL}.
  - Shared constants `Y_GROUND` and `BG_MAX`, which are also used by the wall detector and the renderer.
- One sub-module, `frame_tick_sync`: 2-flop synchronizer plus rising-edge detector producing `tick`.
- All other logic sits in one `always_ff` with a combinational next-state `always_comb`.

## Test plan
- Reset, then 10 ticks with `key_right` held and all `can_*=1` -> `bg_step=10`, `y_pos=368`, `airborne=0`, `facing_left=0`.
- `key_jump` pulse on flat ground (`can_down=1` at the floor) -> `y_pos` 368→356→345→335…, peaks at 368−78=290 after 12 ticks, then falls at speeds 1…8 and lands at exactly 368, `airborne` back to 0.
- `bg_step=0`, `key_left` held for 3 ticks -> `bg_step` stays 0, `facing_left=1`. `bg_step=400`, `key_right` held -> stays 400.
- `can_right=0` at `bg_step=70` with `key_right` held -> `bg_step` stays 70. Release, then `can_right=1` -> 71 on the next tick.
- Mid-rise, `can_up` forced to 0 -> next tick: state FALL, `v=0`, `y_pos` unchanged. Falling with `can_down=0` at `y_pos=206` -> GROUND, `y_pos` holds 206.
- `Reset` asserted at jump apex -> next edge `y_pos=368`, `airborne=0`. A `key_jump` edge given just before reset has no effect on later ticks.
